// File: rtl/seq_detector_param.sv
`default_nettype none
// ============================================================================
// Module      : seq_detector_param
// Description : Serial bit-pattern detector with a run-time loadable pattern,
//               selectable overlapping / non-overlapping matching, a valid
//               strobe on the serial input, a saturating match counter and a
//               matched-prefix progress indicator.
// Ports       : Clock, Reset      - clock, synchronous active-high reset
//               load_en/pattern_in - load a new pattern and restart detection
//               overlap_en         - 1 = overlapping matches allowed
//               w / w_valid        - serial data bit and its qualifier
//               z                  - registered one-cycle match pulse
//               match_count/cnt_sat- saturating match counter, sticky flag
//               progress           - current matched-prefix length
//               pattern_q          - currently active pattern
// Revision    : 1.0 - initial release
// ============================================================================
module seq_detector_param #(
    parameter int                 PAT_LEN   = 4,
    parameter int                 CNT_WIDTH = 8,
    parameter logic [PAT_LEN-1:0] RESET_PAT = 4'b1101
) (
    input  logic                           Clock,
    input  logic                           Reset,
    input  logic                           load_en,
    input  logic [PAT_LEN-1:0]             pattern_in,
    input  logic                           overlap_en,
    input  logic                           w,
    input  logic                           w_valid,
    output logic                           z,
    output logic [CNT_WIDTH-1:0]           match_count,
    output logic                           cnt_sat,
    output logic [$clog2(PAT_LEN+1)-1:0]   progress,
    output logic [PAT_LEN-1:0]             pattern_q
);

    localparam int               c_PW   = $clog2(PAT_LEN + 1);
    localparam logic [c_PW-1:0]  c_FULL = c_PW'(PAT_LEN);

    logic [PAT_LEN-1:0]   pat_q,  pat_d;
    logic [PAT_LEN-1:0]   hist_q, hist_d;
    logic [c_PW-1:0]      fill_q, fill_d;
    logic                 z_q,    z_d;
    logic [CNT_WIDTH-1:0] cnt_q,  cnt_d;
    logic                 sat_q,  sat_d;

    logic [c_PW-1:0]      fill_eff;
    logic [PAT_LEN-1:0]   hist_n;
    logic [c_PW-1:0]      fill_n;
    logic                 hit;
    logic [CNT_WIDTH-1:0] cnt_inc;
    logic [c_PW-1:0]      prog;
    logic [PAT_LEN-1:0]   pre_shift;
    logic [PAT_LEN-1:0]   pre_mask;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        pat_d   = pat_q;
        hist_d  = hist_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        z_d     = 1'b0;

        // A fill value beyond PAT_LEN cannot be reached normally; treat it
        // as the empty-history reset state.
        fill_eff = (fill_q > c_FULL) ? '0 : fill_q;
        fill_d   = fill_eff;

        hist_n  = {hist_q[PAT_LEN-2:0], w};
        fill_n  = (fill_eff == c_FULL) ? c_FULL : fill_eff + 1'b1;
        hit     = (fill_n == c_FULL) && (hist_n == pat_q);
        cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

        if (load_en) begin
            pat_d  = pattern_in;
            hist_d = '0;
            fill_d = '0;
            cnt_d  = '0;
            sat_d  = 1'b0;
        end else if (w_valid) begin
            hist_d = hist_n;
            // Non-overlapping mode forgets all history after a match so the
            // next match has to be built from fresh bits.
            fill_d = (hit && !overlap_en) ? '0 : fill_n;
            z_d    = hit;
            if (hit) begin
                cnt_d = cnt_inc;
                sat_d = sat_q | (&cnt_inc);
            end
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge Clock) begin
        if (Reset) begin
            pat_q  <= RESET_PAT;
            hist_q <= '0;
            fill_q <= '0;
            z_q    <= 1'b0;
            cnt_q  <= '0;
            sat_q  <= 1'b0;
        end else begin
            pat_q  <= pat_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
            z_q    <= z_d;
            cnt_q  <= cnt_d;
            sat_q  <= sat_d;
        end
    end

    // ------------------------------------------------------------------------
    // Progress: longest k (bounded by fill) whose newest k history bits equal
    // the first k pattern bits. Ascending scan so the largest k wins.
    // ------------------------------------------------------------------------
    always_comb begin
        prog      = '0;
        pre_shift = '0;
        pre_mask  = '0;
        for (int k = 1; k <= PAT_LEN; k++) begin
            pre_shift = pat_q >> (PAT_LEN - k);
            pre_mask  = {PAT_LEN{1'b1}} >> (PAT_LEN - k);
            if ((c_PW'(k) <= fill_eff) &&
                (((hist_q ^ pre_shift) & pre_mask) == '0)) begin
                prog = c_PW'(k);
            end
        end
    end

    assign z           = z_q;
    assign match_count = cnt_q;
    assign cnt_sat     = sat_q;
    assign progress    = prog;
    assign pattern_q   = pat_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_detector_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_detector_param
// Description : Directed self-checking bench for seq_detector_param. Two
//               instances share stimulus: the default configuration and a
//               2-bit-counter variant used for saturation behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_detector_param;

    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic       load_en = 1'b0;
    logic [3:0] pattern_in = 4'b0000;
    logic       overlap_en = 1'b1;
    logic       w = 1'b0;
    logic       w_valid = 1'b0;

    logic       z;
    logic [7:0] match_count;
    logic       cnt_sat;
    logic [2:0] progress;
    logic [3:0] pattern_q;

    logic       z2;
    logic [1:0] match_count2;
    logic       cnt_sat2;
    logic [2:0] progress2;
    logic [3:0] pattern_q2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 Clock = ~Clock;

    seq_detector_param #(.PAT_LEN(4), .CNT_WIDTH(8), .RESET_PAT(4'b1101)) u_dut (
        .Clock(Clock), .Reset(Reset), .load_en(load_en), .pattern_in(pattern_in),
        .overlap_en(overlap_en), .w(w), .w_valid(w_valid), .z(z),
        .match_count(match_count), .cnt_sat(cnt_sat), .progress(progress),
        .pattern_q(pattern_q)
    );

    seq_detector_param #(.PAT_LEN(4), .CNT_WIDTH(2), .RESET_PAT(4'b1101)) u_sat (
        .Clock(Clock), .Reset(Reset), .load_en(load_en), .pattern_in(pattern_in),
        .overlap_en(overlap_en), .w(w), .w_valid(w_valid), .z(z2),
        .match_count(match_count2), .cnt_sat(cnt_sat2), .progress(progress2),
        .pattern_q(pattern_q2)
    );

    // One clock of stimulus; outputs are sampled 1 ns after the rising edge.
    task automatic drive(input logic rst, input logic ld, input logic [3:0] p,
                         input logic v, input logic b);
        @(negedge Clock);
        Reset = rst; load_en = ld; pattern_in = p; w_valid = v; w = b;
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset;
        drive(1'b1, 1'b0, 4'b0000, 1'b1, 1'b1);
        n_cmp++; if (z !== 1'b0) begin n_err++; $display("FAIL reset_z: got %0b expected 0", z); end
        n_cmp++; if (match_count !== 8'd0) begin n_err++; $display("FAIL reset_count: got %0d expected 0", match_count); end
        n_cmp++; if (cnt_sat !== 1'b0) begin n_err++; $display("FAIL reset_sat: got %0b expected 0", cnt_sat); end
        n_cmp++; if (progress !== 3'd0) begin n_err++; $display("FAIL reset_progress: got %0d expected 0", progress); end
        n_cmp++; if (pattern_q !== 4'b1101) begin n_err++; $display("FAIL reset_pattern: got %b expected 1101", pattern_q); end
    endtask

    task automatic test_overlap;
        logic [6:0] s;
        logic [6:0] ez;
        s = 7'b1101101; ez = 7'b0001001;
        overlap_en = 1'b1;
        drive(1'b0, 1'b1, 4'b1101, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, 1'b0, 4'b0000, 1'b1, s[6-i]);
            n_cmp++; if (z !== ez[6-i]) begin n_err++; $display("FAIL overlap_z[%0d]: got %0b expected %0b", i+1, z, ez[6-i]); end
            if (i == 2) begin
                n_cmp++; if (progress !== 3'd3) begin n_err++; $display("FAIL overlap_progress_s3: got %0d expected 3", progress); end
            end
        end
        n_cmp++; if (match_count !== 8'd2) begin n_err++; $display("FAIL overlap_count: got %0d expected 2", match_count); end
    endtask

    task automatic test_nonoverlap;
        logic [6:0] s;
        logic [6:0] ez;
        s = 7'b1101101; ez = 7'b0001000;
        overlap_en = 1'b0;
        drive(1'b0, 1'b1, 4'b1101, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, 1'b0, 4'b0000, 1'b1, s[6-i]);
            n_cmp++; if (z !== ez[6-i]) begin n_err++; $display("FAIL nonoverlap_z[%0d]: got %0b expected %0b", i+1, z, ez[6-i]); end
            if (i == 3) begin
                n_cmp++; if (progress !== 3'd0) begin n_err++; $display("FAIL nonoverlap_progress_after_hit: got %0d expected 0", progress); end
            end
        end
        n_cmp++; if (match_count !== 8'd1) begin n_err++; $display("FAIL nonoverlap_count: got %0d expected 1", match_count); end
        // History after the hit is 1,0,1: only the single leading '1' is a prefix.
        n_cmp++; if (progress !== 3'd1) begin n_err++; $display("FAIL nonoverlap_progress_s7: got %0d expected 1", progress); end
    endtask

    task automatic test_all_ones;
        logic [5:0] ez_ov;
        logic [5:0] ez_no;
        ez_ov = 6'b000111; ez_no = 6'b000100;
        overlap_en = 1'b1;
        drive(1'b0, 1'b1, 4'b1111, 1'b0, 1'b0);
        n_cmp++; if (pattern_q !== 4'b1111) begin n_err++; $display("FAIL load_pattern: got %b expected 1111", pattern_q); end
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b0, 4'b0000, 1'b1, 1'b1);
            n_cmp++; if (z !== ez_ov[5-i]) begin n_err++; $display("FAIL ones_ov_z[%0d]: got %0b expected %0b", i+1, z, ez_ov[5-i]); end
        end
        n_cmp++; if (match_count !== 8'd3) begin n_err++; $display("FAIL ones_ov_count: got %0d expected 3", match_count); end
        overlap_en = 1'b0;
        drive(1'b0, 1'b1, 4'b1111, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b0, 4'b0000, 1'b1, 1'b1);
            n_cmp++; if (z !== ez_no[5-i]) begin n_err++; $display("FAIL ones_no_z[%0d]: got %0b expected %0b", i+1, z, ez_no[5-i]); end
        end
        n_cmp++; if (match_count !== 8'd1) begin n_err++; $display("FAIL ones_no_count: got %0d expected 1", match_count); end
        n_cmp++; if (progress !== 3'd2) begin n_err++; $display("FAIL ones_no_progress: got %0d expected 2", progress); end
    endtask

    task automatic test_gaps;
        logic [3:0] s;
        logic [2:0] ep [4];
        s = 4'b1101;
        ep[0] = 3'd1; ep[1] = 3'd2; ep[2] = 3'd3; ep[3] = 3'd4;
        overlap_en = 1'b1;
        drive(1'b0, 1'b1, 4'b1101, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 4'b0000, 1'b1, s[3-i]);
            n_cmp++; if (z !== (i == 3)) begin n_err++; $display("FAIL gaps_z_bit%0d: got %0b expected %0b", i+1, z, (i == 3)); end
            n_cmp++; if (progress !== ep[i]) begin n_err++; $display("FAIL gaps_progress_bit%0d: got %0d expected %0d", i+1, progress, ep[i]); end
            for (int g = 0; g < 3; g++) begin
                drive(1'b0, 1'b0, 4'b0000, 1'b0, 1'($urandom_range(0, 1)));
                n_cmp++; if (z !== 1'b0) begin n_err++; $display("FAIL gaps_z_gap%0d_%0d: got %0b expected 0", i+1, g, z); end
                n_cmp++; if (progress !== ep[i]) begin n_err++; $display("FAIL gaps_progress_gap%0d_%0d: got %0d expected %0d", i+1, g, progress, ep[i]); end
            end
        end
        n_cmp++; if (match_count !== 8'd1) begin n_err++; $display("FAIL gaps_count: got %0d expected 1", match_count); end
    endtask

    task automatic test_saturation;
        int hits;
        overlap_en = 1'b1;
        drive(1'b0, 1'b1, 4'b1111, 1'b0, 1'b0);
        hits = 0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b0, 4'b0000, 1'b1, 1'b1);
            if (i >= 3) hits++;
            n_cmp++; if (z2 !== (i >= 3)) begin n_err++; $display("FAIL sat_z[%0d]: got %0b expected %0b", i+1, z2, (i >= 3)); end
            n_cmp++; if (match_count2 !== 2'((hits > 3) ? 3 : hits)) begin n_err++; $display("FAIL sat_count[%0d]: got %0d expected %0d", i+1, match_count2, (hits > 3) ? 3 : hits); end
            n_cmp++; if (cnt_sat2 !== (hits >= 3)) begin n_err++; $display("FAIL sat_flag[%0d]: got %0b expected %0b", i+1, cnt_sat2, (hits >= 3)); end
        end
        n_cmp++; if (match_count !== 8'd5) begin n_err++; $display("FAIL wide_count: got %0d expected 5", match_count); end
        n_cmp++; if (cnt_sat !== 1'b0) begin n_err++; $display("FAIL wide_sat: got %0b expected 0", cnt_sat); end
        // Load clears the counter and the sticky flag.
        drive(1'b0, 1'b1, 4'b1111, 1'b0, 1'b0);
        n_cmp++; if (match_count2 !== 2'd0 || cnt_sat2 !== 1'b0) begin n_err++; $display("FAIL sat_load_clear: got %0d/%0b expected 0/0", match_count2, cnt_sat2); end
    endtask

    task automatic test_load_midstream;
        logic [2:0] s;
        s = 3'b110;
        overlap_en = 1'b1;
        drive(1'b0, 1'b1, 4'b1101, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 4'b0000, 1'b1, s[2-i]);
        drive(1'b0, 1'b1, 4'b1111, 1'b1, 1'b1);
        n_cmp++; if (progress !== 3'd0) begin n_err++; $display("FAIL midload_progress0: got %0d expected 0", progress); end
        n_cmp++; if (pattern_q !== 4'b1111) begin n_err++; $display("FAIL midload_pattern: got %b expected 1111", pattern_q); end
        drive(1'b0, 1'b0, 4'b0000, 1'b1, 1'b1);
        n_cmp++; if (z !== 1'b0) begin n_err++; $display("FAIL midload_z: got %0b expected 0", z); end
        n_cmp++; if (progress !== 3'd1) begin n_err++; $display("FAIL midload_progress1: got %0d expected 1", progress); end
        n_cmp++; if (match_count !== 8'd0) begin n_err++; $display("FAIL midload_count: got %0d expected 0", match_count); end
    endtask

    task automatic test_reset_midstream;
        logic [2:0] s;
        s = 3'b110;
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 4'b0000, 1'b1, s[2-i]);
        drive(1'b1, 1'b0, 4'b0000, 1'b1, 1'b1);
        n_cmp++; if (progress !== 3'd0) begin n_err++; $display("FAIL midreset_progress: got %0d expected 0", progress); end
        n_cmp++; if (z !== 1'b0) begin n_err++; $display("FAIL midreset_z: got %0b expected 0", z); end
        n_cmp++; if (pattern_q !== 4'b1101) begin n_err++; $display("FAIL midreset_pattern: got %b expected 1101", pattern_q); end
        // Continue 1,0,1 after reset: only 3 bits since reset, no match.
        drive(1'b0, 1'b0, 4'b0000, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 4'b0000, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 4'b0000, 1'b1, 1'b1);
        n_cmp++; if (z !== 1'b0) begin n_err++; $display("FAIL midreset_nospan_z: got %0b expected 0", z); end
    endtask

    initial begin
        test_reset();
        test_overlap();
        test_nonoverlap();
        test_all_ones();
        test_gaps();
        test_saturation();
        test_load_midstream();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
